stack_calc_ctrl: RTL

//  Command sequencer for the result/opcode LIFO in the lab2 calculator.
//  - Accepts PUSH/POP/EVAL/CLEAR commands over a valid/ready port.
//  - Drives the LIFO push/pop lines and runs its flag/readflag set-then-reset handshake.
//  - EVAL pops two operands, applies an ALU op, pushes the result.
//  - One response per command.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/calc_alu.sv | 32 +++
 rtl/stack_calc_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared encodings for the stack calculator controller.
//   cmd_op_e : command codes carried on cmd_op
//   alu_op_e : ALU operation codes carried on cmd_opcode for EVAL
//   state_e  : sequencer FSM states
package calc_pkg;

    typedef enum logic [1:0] {
        CMD_PUSH  = 2'b00,
        CMD_POP   = 2'b01,
        CMD_EVAL  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SHL   = 3'b101,
        ALU_SHR   = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_ALU, S_DONE, S_ERR
    } state_e;

    // Handshake watchdog limit in cycles (only used with CALC_HS_TIMEOUT_EN).
    localparam int WDOG_LIMIT = 15;

endpackage

// File: rtl/calc_alu.sv
// calc_alu: combinational ALU, R = A op B truncated to RW bits.
//   a, b : operands (b is the value that was on top of the stack)
//   op   : ALU op code (low 3 bits used)
//   r    : result
module calc_alu
    import calc_pkg::*;
#(
    parameter int RW = 6,
    parameter int OW = 3
) (
    input  logic [RW-1:0] a,
    input  logic [RW-1:0] b,
    input  logic [OW-1:0] op,
    output logic [RW-1:0] r
);

    always_comb begin
        r = '0;
        case (alu_op_e'(op[2:0]))
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_AND:   r = a & b;
            ALU_OR:    r = a | b;
            ALU_XOR:   r = a ^ b;
            ALU_SHL:   r = a << 1;
            ALU_SHR:   r = a >> 1;
            ALU_PASSB: r = b;
            default:   r = '0;
        endcase
    end

endmodule

// File: rtl/stack_calc_ctrl.sv
// stack_calc_ctrl: command sequencer for the calculator result/opcode LIFO.
// Accepts PUSH/POP/EVAL/CLEAR over valid/ready, runs the LIFO push/pop
// set-then-reset flag handshakes and returns one response per command.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   cmd_valid/cmd_ready          command handshake (ready = idle)
//   cmd_op/cmd_data/cmd_opcode   command, PUSH operand, PUSH tag / EVAL op
//   st_*                         LIFO control and status
//   rsp_valid/rsp_data/rsp_err   one-cycle response
// Build option: define CALC_HS_TIMEOUT_EN to add a 15-cycle handshake watchdog.
module stack_calc_ctrl
    import calc_pkg::*;
#(
    parameter int DEPTH = 6,
    parameter int RW    = 6,
    parameter int OW    = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [RW-1:0] cmd_data,
    input  logic [OW-1:0] cmd_opcode,
    output logic          st_push,
    output logic          st_pop,
    output logic [RW-1:0] st_resultin,
    output logic [OW-1:0] st_opcodeselin,
    output logic          st_flag_reset,
    output logic          st_read_flag_reset,
    input  logic          st_flag,
    input  logic          st_readflag,
    input  logic [RW-1:0] st_resulttos,
    output logic          rsp_valid,
    output logic [RW-1:0] rsp_data,
    output logic          rsp_err
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e        state, state_next;
    logic [CW-1:0] count;
    cmd_op_e       op_q;
    logic [RW-1:0] data_q, a_q, b_q, res_q, alu_r;
    logic [OW-1:0] opc_q;
    logic          phase;        // EVAL: 0 = popping B, 1 = popping A
    logic          accept;
    logic          hs_timeout;

    assign accept = cmd_valid && cmd_ready;

    calc_alu #(.RW(RW), .OW(OW)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (opc_q),
        .r  (alu_r)
    );

`ifdef CALC_HS_TIMEOUT_EN
    logic [3:0] wdog;
    logic       wait_st, hs_done;

    assign wait_st = (state == S_WR) || (state == S_WR_ACK) ||
                     (state == S_RD) || (state == S_RD_ACK);
    assign hs_done = ((state == S_WR)     &&  st_flag)     ||
                     ((state == S_WR_ACK) && !st_flag)     ||
                     ((state == S_RD)     &&  st_readflag) ||
                     ((state == S_RD_ACK) && !st_readflag);
    // wdog holds the number of cycles already spent in the current state.
    assign hs_timeout = wait_st && !hs_done && (wdog == 4'(WDOG_LIMIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 wdog <= '0;
        else if (state != state_next) wdog <= '0;
        else if (wdog != 4'hF)        wdog <= wdog + 4'd1;
    end
`else
    assign hs_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next         = state;
        cmd_ready          = 1'b0;
        st_push            = 1'b0;
        st_pop             = 1'b0;
        st_resultin        = '0;
        st_opcodeselin     = '0;
        st_flag_reset      = 1'b0;
        st_read_flag_reset = 1'b0;
        rsp_valid          = 1'b0;
        rsp_data           = '0;
        rsp_err            = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op_e'(cmd_op))
                        CMD_PUSH:  state_next = (count == CW'(DEPTH)) ? S_ERR : S_WR;
                        CMD_POP:   state_next = (count == '0)         ? S_ERR : S_RD;
                        CMD_EVAL:  state_next = (count <  CW'(2))     ? S_ERR : S_RD;
                        default:   state_next = (count == '0)         ? S_DONE : S_RD;
                    endcase
                end
            end
            S_WR: begin
                st_push        = 1'b1;
                st_resultin    = (op_q == CMD_EVAL) ? res_q : data_q;
                st_opcodeselin = opc_q;
                if (st_flag) state_next = S_WR_ACK;
            end
            S_WR_ACK: begin
                st_flag_reset = 1'b1;
                if (!st_flag) state_next = S_DONE;
            end
            S_RD: begin
                st_pop = 1'b1;
                if (st_readflag) state_next = S_RD_ACK;
            end
            S_RD_ACK: begin
                st_read_flag_reset = 1'b1;
                if (!st_readflag) begin
                    if (op_q == CMD_EVAL)
                        state_next = phase ? S_ALU : S_RD;
                    else if (op_q == CMD_CLEAR && count > CW'(1))
                        state_next = S_RD;
                    else
                        state_next = S_DONE;
                end
            end
            S_ALU:  state_next = S_WR;
            S_DONE: begin
                rsp_valid = 1'b1;
                case (op_q)
                    CMD_PUSH: rsp_data = data_q;
                    CMD_POP:  rsp_data = b_q;
                    CMD_EVAL: rsp_data = res_q;
                    default:  rsp_data = '0;
                endcase
                state_next = S_IDLE;
            end
            S_ERR: begin
                rsp_valid  = 1'b1;
                rsp_err    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Watchdog abort: the next cycle is ERR, which drops every strobe.
        if (hs_timeout) state_next = S_ERR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            op_q   <= CMD_PUSH;
            data_q <= '0;
            opc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            phase  <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= cmd_op_e'(cmd_op);
                data_q <= cmd_data;
                opc_q  <= cmd_opcode;
                phase  <= 1'b0;
            end
            // First pop lands in B (top of stack), second in A.
            if (state == S_RD && st_readflag) begin
                if (phase) a_q <= st_resulttos;
                else       b_q <= st_resulttos;
            end
            if (state == S_RD_ACK && !st_readflag) begin
                count <= count - CW'(1);
                phase <= 1'b1;
            end
            if (state == S_WR_ACK && !st_flag) count <= count + CW'(1);
            if (state == S_ALU) res_q <= alu_r;
        end
    end

endmodule
